// File: rtl/mont_pkg.sv
// Shared constants and encodings for the P-192 Montgomery exponentiation datapath.
// Contents:
//   K, LOGK          operand width and exponent bit-index width
//   M                P-192 prime
//   R_MOD_M          2^K mod M (Montgomery one)
//   R2_MOD_M         2^2K mod M (converts a plain residue into the Montgomery domain)
//   main_state_e     sequencer main-state encoding
//   hs_phase_e       per-multiplication handshake phases
package mont_pkg;

  localparam int unsigned K    = 192;
  localparam int unsigned LOGK = 8;

  localparam logic [K-1:0] M =
      192'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe_ffff_ffff_ffff_ffff;
  localparam logic [K-1:0] R_MOD_M  = 192'h1_0000_0000_0000_0001;
  localparam logic [K-1:0] R2_MOD_M = 192'h1_0000_0000_0000_0002_0000_0000_0000_0001;

  typedef enum logic [2:0] {
    StIdle,
    StToM,
    StSqr,
    StMul,
    StFromM,
    StFin
  } main_state_e;

  typedef enum logic [1:0] {
    PhIdle,
    PhPrep,
    PhIssue,
    PhWait
  } hs_phase_e;

endpackage

// File: rtl/mm_handshake.sv
// Runs one Montgomery multiplication on the shared bit-serial multiplier.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req             one-cycle request; accepted only while idle, latches a/b
//   a, b            operands for the requested multiplication
//   mm_done, mm_z   multiplier status and result
//   mm_x, mm_y      operands to the multiplier, held from PREP through WAIT
//   mm_start        multiplier start
//   ack             one-cycle pulse; z_q holds the product from that cycle on
//   z_q             captured product
module mm_handshake
  import mont_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         mm_done,
  input  logic [K-1:0] mm_z,
  output logic [K-1:0] mm_x,
  output logic [K-1:0] mm_y,
  output logic         mm_start,
  output logic         ack,
  output logic [K-1:0] z_q
);

  hs_phase_e phase_q;
  logic      prep_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= PhIdle;
      prep_cnt_q <= 1'b0;
      mm_x       <= '0;
      mm_y       <= '0;
      mm_start   <= 1'b0;
      ack        <= 1'b0;
      z_q        <= '0;
    end else begin
      ack <= 1'b0;
      unique case (phase_q)
        PhIdle: begin
          if (req) begin
            mm_x       <= a;
            mm_y       <= b;
            prep_cnt_q <= 1'b0;
            phase_q    <= PhPrep;
          end
        end
        // Keep start low for at least two cycles so the multiplier can arm itself.
        PhPrep: begin
          prep_cnt_q <= 1'b1;
          if (prep_cnt_q && mm_done) begin
            mm_start <= 1'b1;
            phase_q  <= PhIssue;
          end
        end
        // The multiplier acknowledges by dropping done; it may take several cycles.
        PhIssue: begin
          if (!mm_done) begin
            mm_start <= 1'b0;
            phase_q  <= PhWait;
          end
        end
        PhWait: begin
          if (mm_done) begin
            z_q     <= mm_z;
            ack     <= 1'b1;
            phase_q <= PhIdle;
          end
        end
        default: phase_q <= PhIdle;
      endcase
    end
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation sequencer: result = base^exp mod M, left-to-right square-and-multiply
// over all K exponent bits, using one shared Montgomery multiplier (z = x*y*2^-K mod M).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin an operation (sampled only when idle)
//   base, exp           operands, latched on an accepted start
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse, result valid
//   result              base^exp mod M, held until the next accepted start
//   mm_x, mm_y, mm_start  multiplier operands and start
//   mm_done, mm_z       multiplier status and result
module mont_exp_ctrl
  import mont_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] base,
  input  logic [K-1:0] exp,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] result,
  output logic [K-1:0] mm_x,
  output logic [K-1:0] mm_y,
  output logic         mm_start,
  input  logic         mm_done,
  input  logic [K-1:0] mm_z
);

  main_state_e     state_q;
  logic [K-1:0]    base_q;
  logic [K-1:0]    exp_q;
  logic [K-1:0]    bm_q;   // base in the Montgomery domain
  logic [K-1:0]    acc_q;  // running accumulator, Montgomery domain
  logic [K-1:0]    res_q;  // accumulator converted back to a plain residue
  logic [LOGK-1:0] idx_q;
  logic            issued_q;

  logic         req;
  logic         ack;
  logic [K-1:0] hs_a;
  logic [K-1:0] hs_b;
  logic [K-1:0] hs_z;

  always_comb begin
    hs_a = '0;
    hs_b = '0;
    unique case (state_q)
      StToM: begin
        hs_a = base_q;
        hs_b = R2_MOD_M;
      end
      StSqr: begin
        hs_a = acc_q;
        hs_b = acc_q;
      end
      StMul: begin
        hs_a = acc_q;
        hs_b = bm_q;
      end
      // Multiplying by plain 1 strips the 2^K factor.
      StFromM: begin
        hs_a = acc_q;
        hs_b = K'(1);
      end
      default: ;
    endcase
  end

  // One request per multiplying state; issued_q blocks re-requests until the ack.
  assign req = !issued_q && (state_q inside {StToM, StSqr, StMul, StFromM});

  mm_handshake u_mm_handshake (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .a        (hs_a),
    .b        (hs_b),
    .mm_done  (mm_done),
    .mm_z     (mm_z),
    .mm_x     (mm_x),
    .mm_y     (mm_y),
    .mm_start (mm_start),
    .ack      (ack),
    .z_q      (hs_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      base_q   <= '0;
      exp_q    <= '0;
      bm_q     <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      issued_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      if (req) begin
        issued_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q  <= base;
            exp_q   <= exp;
            idx_q   <= LOGK'(K - 1);
            acc_q   <= R_MOD_M;
            busy    <= 1'b1;
            state_q <= StToM;
          end
        end
        StToM: begin
          if (ack) begin
            bm_q     <= hs_z;
            issued_q <= 1'b0;
            state_q  <= StSqr;
          end
        end
        StSqr: begin
          if (ack) begin
            acc_q    <= hs_z;
            issued_q <= 1'b0;
            if (exp_q[idx_q]) begin
              state_q <= StMul;
            end else if (idx_q == '0) begin
              state_q <= StFromM;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= StSqr;
            end
          end
        end
        StMul: begin
          if (ack) begin
            acc_q    <= hs_z;
            issued_q <= 1'b0;
            if (idx_q == '0) begin
              state_q <= StFromM;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= StSqr;
            end
          end
        end
        StFromM: begin
          if (ack) begin
            res_q    <= hs_z;
            issued_q <= 1'b0;
            state_q  <= StFin;
          end
        end
        StFin: begin
          result  <= res_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural bit-serial Montgomery multiplier with randomised
// acknowledge/latency, a plain bignum modexp reference, directed table vectors and corner
// sequences (mid-run start, reset mid-run, Fermat inverse, random operands).
module tb_mont_exp_ctrl;
  import mont_pkg::*;

  localparam int Budget = 8000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [K-1:0] base_in = '0;
  logic [K-1:0] exp_in = '0;
  logic         busy;
  logic         done;
  logic [K-1:0] result;
  logic [K-1:0] mm_x;
  logic [K-1:0] mm_y;
  logic         mm_start;
  logic         mm_done;
  logic [K-1:0] mm_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mont_exp_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base_in),
    .exp      (exp_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mm_x     (mm_x),
    .mm_y     (mm_y),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .mm_z     (mm_z)
  );

  // ---------------- multiplier model ----------------
  function automatic logic [K-1:0] mont(input logic [K-1:0] x, input logic [K-1:0] y);
    logic [K+1:0] t;
    t = '0;
    for (int i = 0; i < K; i++) begin
      if (x[i]) t = t + {2'b00, y};
      if (t[0]) t = t + {2'b00, M};
      t = t >> 1;
    end
    if (t >= {2'b00, M}) t = t - {2'b00, M};
    return t[K-1:0];
  endfunction

  logic [1:0]   m_st = 2'd0;  // 0: needs start=0, 1: armed, 2: running
  logic         ack_wait = 1'b0;
  logic [1:0]   lat = 2'd0;
  logic [K-1:0] x_l = '0;
  logic [K-1:0] y_l = '0;
  int           mm_acks = 0;
  int           stab_viol = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_st     <= 2'd0;
      mm_done  <= 1'b1;
      mm_z     <= '0;
      ack_wait <= 1'b0;
      lat      <= 2'd0;
    end else begin
      case (m_st)
        2'd0: if (!mm_start) begin
          m_st     <= 2'd1;
          ack_wait <= 1'($urandom_range(0, 1));
        end
        2'd1: if (mm_start) begin
          if (ack_wait) ack_wait <= 1'b0;
          else begin
            m_st    <= 2'd2;
            mm_done <= 1'b0;
            x_l     <= mm_x;
            y_l     <= mm_y;
            lat     <= 2'($urandom_range(1, 3));
            mm_acks <= mm_acks + 1;
          end
        end
        default: begin
          if (mm_x !== x_l || mm_y !== y_l) stab_viol <= stab_viol + 1;
          if (lat == 2'd0) begin
            mm_z    <= mont(x_l, y_l);
            mm_done <= 1'b1;
            m_st    <= 2'd0;
          end else begin
            lat <= lat - 2'd1;
          end
        end
      endcase
    end
  end

  // ---------------- reference ----------------
  function automatic logic [K-1:0] mulmod(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [2*K-1:0] p;
    logic [2*K-1:0] mw;
    mw = {{K{1'b0}}, M};
    p  = {{K{1'b0}}, a} * {{K{1'b0}}, b};
    p  = p % mw;
    return p[K-1:0];
  endfunction

  function automatic logic [K-1:0] modexp(input logic [K-1:0] b, input logic [K-1:0] e);
    logic [K-1:0] r;
    r = K'(1);
    for (int i = K - 1; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, b);
    end
    return r;
  endfunction

  function automatic logic [K-1:0] rand_k();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Runs one operation. poke_at>0 pulses start with different operands that many cycles in.
  task automatic run_op(input logic [K-1:0] b, input logic [K-1:0] e, input int poke_at,
                        output logic [K-1:0] r, output int nm, output int nd);
    int a0;
    int cyc;
    @(negedge clk);
    base_in = b;
    exp_in  = e;
    start   = 1'b1;
    a0      = mm_acks;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", K'(busy), K'(1));
    nd  = 0;
    cyc = 0;
    while (nd == 0 && cyc < Budget) begin
      @(negedge clk);
      cyc++;
      if (start) begin
        start = 1'b0;
        chk("busy_after_ignored_start", K'(busy), K'(1));
      end
      if (poke_at > 0 && cyc == poke_at && !done) begin
        base_in = K'(16'h55aa);
        exp_in  = K'(16'hffff);
        start   = 1'b1;
      end
      if (done) nd++;
    end
    if (nd == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", Budget);
    end
    chk("busy_low_at_done", K'(busy), K'(0));
    r  = result;
    nm = mm_acks - a0;
    @(negedge clk);
    if (done) nd++;
    chk("result_held", result, r);
  endtask

  typedef struct {
    logic [K-1:0] b;
    logic [K-1:0] e;
    logic [K-1:0] res;
    int           nm;
  } vec_t;

  vec_t         vecs[6];
  logic [K-1:0] r;
  logic [K-1:0] rb;
  logic [K-1:0] re;
  int           nm;
  int           nd;
  int           cyc;

  initial begin
    vecs[0] = '{b: K'(5),  e: K'(0),  res: K'(1),    nm: 194};
    vecs[1] = '{b: K'(2),  e: K'(10), res: K'(1024), nm: 196};
    vecs[2] = '{b: M - 1,  e: K'(2),  res: K'(1),    nm: 195};
    vecs[3] = '{b: M - 1,  e: K'(3),  res: M - 1,    nm: 196};
    vecs[4] = '{b: K'(0),  e: K'(7),  res: K'(0),    nm: 197};
    vecs[5] = '{b: K'(3),  e: K'(5),  res: K'(243),  nm: 196};

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", K'(busy), K'(0));
    chk("reset_done", K'(done), K'(0));
    chk("reset_result", result, K'(0));
    chk("reset_mm_start", K'(mm_start), K'(0));
    chk("reset_mm_x", mm_x, K'(0));
    chk("reset_mm_y", mm_y, K'(0));

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].b, vecs[v].e, 0, r, nm, nd);
      chk($sformatf("vec%0d_result", v), r, vecs[v].res);
      chk_int($sformatf("vec%0d_mults", v), nm, vecs[v].nm);
      chk_int($sformatf("vec%0d_done_pulses", v), nd, 1);
    end

    // Fermat inverse: popcount(M-2) = 190.
    run_op(K'(16'h1234), M - 2, 0, r, nm, nd);
    chk("fermat_inverse", mulmod(r, K'(16'h1234)), K'(1));
    chk_int("fermat_mults", nm, 2 + 192 + 190);

    // Start pulsed mid-run is ignored; 7^9 = 40353607.
    run_op(K'(7), K'(9), 600, r, nm, nd);
    chk("midrun_start_result", r, K'(40353607));
    chk_int("midrun_start_mults", nm, 196);
    chk_int("midrun_start_done_pulses", nd, 1);

    // Reset during SQR at bit index 100.
    @(negedge clk);
    base_in = K'(11);
    exp_in  = rand_k();
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!(dut.state_q == StSqr && dut.idx_q == 8'd100) && cyc < Budget) begin
      @(negedge clk);
      cyc++;
    end
    chk_int("reach_sqr_i100", (cyc < Budget) ? 1 : 0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", K'(busy), K'(0));
    chk("midreset_mm_start", K'(mm_start), K'(0));
    chk("midreset_result", result, K'(0));
    reset = 1'b0;
    rb = rand_k();
    if (rb >= M) rb = rb - M;
    re = rand_k();
    run_op(rb, re, 0, r, nm, nd);
    chk("post_reset_result", r, modexp(rb, re));
    chk_int("post_reset_mults", nm, 2 + K + $countones(re));

    // Random operands.
    for (int n = 0; n < 12; n++) begin
      rb = rand_k();
      if (rb >= M) rb = rb - M;
      re = rand_k();
      run_op(rb, re, 0, r, nm, nd);
      chk($sformatf("rand%0d_result", n), r, modexp(rb, re));
      chk_int($sformatf("rand%0d_mults", n), nm, 2 + K + $countones(re));
      chk_int($sformatf("rand%0d_done_pulses", n), nd, 1);
    end

    chk_int("operands_stable_while_busy", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
